// File: rtl/asg_itp.sv
// Table-driven arbitrary signal generator: fractional phase accumulator, optional
// linear interpolation, finite/infinite period count, AXI-stream output with backpressure.
module asg_itp #(
  parameter int DW = 14,
  parameter int AW = 14,
  parameter int FW = 16,
  parameter int CW = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             bus_wen,
  input  logic [AW-1:0]    bus_addr,
  input  logic [DW-1:0]    bus_wdata,
  input  logic [AW:0]      cfg_siz,
  input  logic [AW+FW-1:0] cfg_ste,
  input  logic [AW+FW-1:0] cfg_off,
  input  logic [CW-1:0]    cfg_cyc,
  input  logic             cfg_itp,
  input  logic             ctl_str,
  input  logic             ctl_stp,
  output logic             sts_run,
  output logic [CW-1:0]    sts_cyc,
  output logic             evo_per,
  output logic [DW-1:0]    sto_tdata,
  output logic             sto_tvalid,
  input  logic             sto_tready,
  output logic             sto_tlast
);
  localparam int PW = AW + FW;

  typedef enum logic {IDLE, RUN} state_t;

  function automatic logic signed [DW+FW:0] interp_prod(
    input logic signed [DW-1:0] xi,
    input logic signed [DW-1:0] xj,
    input logic        [FW-1:0] f
  );
    logic signed [DW:0] d;
    d = (DW+1)'(xj) - (DW+1)'(xi);
    return d * $signed({1'b0, f});
  endfunction

  // Arithmetic shift floors toward -inf; the sum always fits DW so no saturation.
  function automatic logic signed [DW-1:0] interp_sum(
    input logic signed [DW-1:0] xi,
    input logic signed [DW+FW:0] prod
  );
    logic signed [DW+FW:0] step;
    step = prod >>> FW;
    return xi + step[DW-1:0];
  endfunction

  state_t                 state_q, state_d;
  logic [PW-1:0]          ph_q, ph_d;
  logic [CW-1:0]          cyc_q, cyc_d;
  logic                   evo_q, evo_d;
  logic                   en, issue, wrap, last;
  logic [PW:0]            sum, lim;
  logic [AW-1:0]          idx_i, idx_j;
  logic [AW:0]            idx_inc;

  logic signed [DW-1:0]   mem [2**AW];
  logic signed [DW-1:0]   xi_p1_q, xj_p1_q;
  logic [FW-1:0]          f_p1_q;
  logic                   vld_p1_q, vld_p1_d, last_p1_q, last_p1_d;
  logic signed [DW-1:0]   xi_p2_q, xi_p2_d;
  logic signed [DW+FW:0]  prod_p2_q, prod_p2_d;
  logic                   vld_p2_q, vld_p2_d, last_p2_q, last_p2_d;
  logic [DW-1:0]          tdata_q, tdata_d;
  logic                   tvalid_q, tvalid_d, tlast_q, tlast_d;

  assign en = sto_tready | ~tvalid_q;

  // S0: phase accumulator and issue control
  always_comb begin
    lim     = {cfg_siz, {FW{1'b0}}};
    sum     = {1'b0, ph_q} + {1'b0, cfg_ste};
    wrap    = (sum >= lim);
    idx_i   = ph_q[PW-1:FW];
    idx_inc = {1'b0, idx_i} + {{AW{1'b0}}, 1'b1};
    idx_j   = (idx_inc == cfg_siz) ? '0 : idx_inc[AW-1:0];
    last    = wrap && (cfg_cyc != '0) && ((cyc_q + CW'(1)) == cfg_cyc);
    issue   = (state_q == RUN) && en && !ctl_str && !ctl_stp;
  end

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    cyc_d   = cyc_q;
    evo_d   = en ? 1'b0 : evo_q;
    if (ctl_stp) begin
      state_d = IDLE;
    end else if (ctl_str) begin
      state_d = RUN;
      ph_d    = cfg_off;
      cyc_d   = '0;
    end else if (issue) begin
      ph_d = wrap ? PW'(sum - lim) : sum[PW-1:0];
      if (wrap) begin
        cyc_d = cyc_q + CW'(1);
        evo_d = 1'b1;
      end
      if (last) state_d = IDLE;
    end
  end

  // S1: table read (read-first against a same-cycle write); storage is never reset
  always_ff @(posedge clk) begin
    if (bus_wen) mem[bus_addr] <= bus_wdata;
    if (en) begin
      xi_p1_q <= mem[idx_i];
      xj_p1_q <= mem[idx_j];
      f_p1_q  <= cfg_itp ? ph_q[FW-1:0] : '0;
    end
  end

  // S2: difference and multiply; S3: sum into the output register
  always_comb begin
    vld_p1_d  = en ? issue : vld_p1_q;
    last_p1_d = en ? (issue && last) : last_p1_q;
    vld_p2_d  = en ? vld_p1_q : vld_p2_q;
    last_p2_d = en ? last_p1_q : last_p2_q;
    xi_p2_d   = en ? xi_p1_q : xi_p2_q;
    prod_p2_d = en ? interp_prod(xi_p1_q, xj_p1_q, f_p1_q) : prod_p2_q;
    tvalid_d  = en ? vld_p2_q : tvalid_q;
    tlast_d   = en ? (vld_p2_q && last_p2_q) : tlast_q;
    tdata_d   = en ? interp_sum(xi_p2_q, prod_p2_q) : tdata_q;
  end

  always_ff @(posedge clk) begin
    xi_p2_q   <= xi_p2_d;
    prod_p2_q <= prod_p2_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      ph_q      <= '0;
      cyc_q     <= '0;
      evo_q     <= 1'b0;
      vld_p1_q  <= 1'b0;
      last_p1_q <= 1'b0;
      vld_p2_q  <= 1'b0;
      last_p2_q <= 1'b0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      tdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      cyc_q     <= cyc_d;
      evo_q     <= evo_d;
      vld_p1_q  <= vld_p1_d;
      last_p1_q <= last_p1_d;
      vld_p2_q  <= vld_p2_d;
      last_p2_q <= last_p2_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      tdata_q   <= tdata_d;
    end
  end

  assign sts_run    = (state_q == RUN);
  assign sts_cyc    = cyc_q;
  assign evo_per    = evo_q;
  assign sto_tdata  = tdata_q;
  assign sto_tvalid = tvalid_q;
  assign sto_tlast  = tlast_q;

endmodule

// File: tb/tb_asg_itp.sv
// Scoreboard bench for asg_itp: directed vectors push expected samples, a monitor pops on handshakes.
module tb_asg_itp;
  localparam int DW = 14, AW = 14, FW = 16, CW = 16;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             bus_wen = 1'b0;
  logic [AW-1:0]    bus_addr = '0;
  logic [DW-1:0]    bus_wdata = '0;
  logic [AW:0]      cfg_siz = '0;
  logic [AW+FW-1:0] cfg_ste = '0;
  logic [AW+FW-1:0] cfg_off = '0;
  logic [CW-1:0]    cfg_cyc = '0;
  logic             cfg_itp = 1'b0;
  logic             ctl_str = 1'b0;
  logic             ctl_stp = 1'b0;
  logic             sts_run;
  logic [CW-1:0]    sts_cyc;
  logic             evo_per;
  logic [DW-1:0]    sto_tdata;
  logic             sto_tvalid;
  logic             sto_tready = 1'b1;
  logic             sto_tlast;

  asg_itp #(.DW(DW), .AW(AW), .FW(FW), .CW(CW)) dut (
    .clk(clk), .rstn(rstn),
    .bus_wen(bus_wen), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .cfg_siz(cfg_siz), .cfg_ste(cfg_ste), .cfg_off(cfg_off), .cfg_cyc(cfg_cyc), .cfg_itp(cfg_itp),
    .ctl_str(ctl_str), .ctl_stp(ctl_stp),
    .sts_run(sts_run), .sts_cyc(sts_cyc), .evo_per(evo_per),
    .sto_tdata(sto_tdata), .sto_tvalid(sto_tvalid), .sto_tready(sto_tready), .sto_tlast(sto_tlast)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int out_cnt = 0;
  int evo_cnt = 0;
  bit mon_off = 1'b0;
  bit rand_rdy = 1'b0;
  logic [DW:0] exp_q [$];

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int v, input bit l);
    logic [DW-1:0] t;
    t = v[DW-1:0];
    exp_q.push_back({l, t});
  endtask

  task automatic write_tab(input int a, input int v);
    bus_wen   = 1'b1;
    bus_addr  = a[AW-1:0];
    bus_wdata = v[DW-1:0];
    tick();
    bus_wen   = 1'b0;
  endtask

  task automatic start();
    ctl_str = 1'b1;
    tick();
    ctl_str = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < maxc) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout_left", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  // Monitor: pop on every handshake, and hold-stability during stalls
  initial begin
    logic [DW:0]   e;
    logic [DW-1:0] held_d;
    logic          held_l;
    bit            stall_prev;
    stall_prev = 1'b0;
    held_d = '0;
    held_l = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn && !mon_off) begin
        if (stall_prev) begin
          chk("stall_tdata", sto_tdata, held_d);
          chk("stall_tlast", sto_tlast, held_l);
        end
        if (sto_tvalid && sto_tready) begin
          out_cnt++;
          if (exp_q.size() == 0) begin
            chk("unexpected_sample", sto_tdata, -1);
          end else begin
            e = exp_q.pop_front();
            chk("sample_data", $signed(sto_tdata), $signed(e[DW-1:0]));
            chk("sample_last", sto_tlast, e[DW]);
          end
        end
        stall_prev = sto_tvalid && !sto_tready;
        held_d = sto_tdata;
        held_l = sto_tlast;
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (evo_per) evo_cnt++;
  end

  initial forever begin
    @(posedge clk);
    #2;
    if (rand_rdy) sto_tready = 1'($urandom_range(0, 1));
  end

  initial begin
    int n, mark;
    // Reset state
    #12;
    chk("rst_tvalid", sto_tvalid, 0);
    chk("rst_tdata", sto_tdata, 0);
    chk("rst_tlast", sto_tlast, 0);
    chk("rst_run", sts_run, 0);
    chk("rst_cyc", sts_cyc, 0);
    chk("rst_evo", evo_per, 0);
    @(posedge clk); #1 rstn = 1'b1;
    tick();

    // Burst, nearest-lower, two periods
    for (int k = 0; k < 8; k++) write_tab(k, 100 * k);
    cfg_siz = 9'(8) ; cfg_ste = 30'(1) << FW; cfg_off = '0; cfg_cyc = 16'(2); cfg_itp = 1'b0;
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 8; k++) push(100 * k, (p == 1) && (k == 7));
    evo_cnt = 0;
    start();
    chk("burst_run_after_str", sts_run, 1);
    tick(); tick();
    chk("burst_no_valid_early", sto_tvalid, 0);
    tick();
    chk("burst_first_valid_lat", sto_tvalid, 1);
    drain(60);
    repeat (5) tick();
    chk("burst_evo_pulses", evo_cnt, 2);
    chk("burst_sts_cyc", sts_cyc, 2);
    chk("burst_run_done", sts_run, 0);

    // Linear interpolation, wrap reads x[0] as the upper neighbour
    write_tab(0, 0); write_tab(1, 1000); write_tab(2, -1000);
    cfg_siz = 9'(3); cfg_ste = 30'h4000; cfg_cyc = 16'(1); cfg_itp = 1'b1;
    push(0, 0); push(250, 0); push(500, 0); push(750, 0);
    push(1000, 0); push(500, 0); push(0, 0); push(-500, 0);
    push(-1000, 0); push(-750, 0); push(-500, 0); push(-250, 1);
    start();
    drain(60);
    repeat (5) tick();
    chk("itp_sts_cyc", sts_cyc, 1);
    chk("itp_run_done", sts_run, 0);

    // Backpressure: same burst as the first test under random tready
    for (int k = 0; k < 8; k++) write_tab(k, 100 * k);
    cfg_siz = 9'(8); cfg_ste = 30'(1) << FW; cfg_cyc = 16'(2); cfg_itp = 1'b0;
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 8; k++) push(100 * k, (p == 1) && (k == 7));
    rand_rdy = 1'b1;
    start();
    drain(400);
    rand_rdy = 1'b0;
    sto_tready = 1'b1;
    repeat (5) tick();
    chk("bp_sts_cyc", sts_cyc, 2);
    chk("bp_run_done", sts_run, 0);

    // Stop during an infinite run
    cfg_cyc = '0;
    for (int k = 0; k < 30; k++) push(100 * (k % 8), 0);
    out_cnt = 0;
    start();
    n = 0;
    while (out_cnt < 5 && n < 50) begin tick(); n++; end
    chk("stop_reached_5_outputs", out_cnt >= 5, 1);
    ctl_stp = 1'b1;
    tick();
    ctl_stp = 1'b0;
    chk("stop_run_cleared", sts_run, 0);
    mark = out_cnt;
    repeat (10) tick();
    chk("stop_drain_at_most_3", (out_cnt - mark) <= 3, 1);
    exp_q.delete();

    // Restart from offset 3, one period
    cfg_off = 30'(3) << FW; cfg_cyc = 16'(1);
    push(300, 0); push(400, 0); push(500, 0); push(600, 0); push(700, 1);
    start();
    drain(40);
    repeat (3) tick();
    chk("restart_run_done", sts_run, 0);

    // Start and stop together: stop wins
    ctl_str = 1'b1; ctl_stp = 1'b1;
    tick();
    ctl_str = 1'b0; ctl_stp = 1'b0;
    chk("strstp_stays_idle", sts_run, 0);
    repeat (8) tick();
    chk("strstp_no_valid", sto_tvalid, 0);

    // Asynchronous reset mid-run
    cfg_off = '0; cfg_cyc = '0;
    mon_off = 1'b1;
    start();
    repeat (12) tick();
    chk("prerst_running", sts_run, 1);
    chk("prerst_cyc_nonzero", sts_cyc != 0, 1);
    #3 rstn = 1'b0;
    #1;
    chk("arst_tvalid", sto_tvalid, 0);
    chk("arst_tdata", sto_tdata, 0);
    chk("arst_tlast", sto_tlast, 0);
    chk("arst_run", sts_run, 0);
    chk("arst_cyc", sts_cyc, 0);
    chk("arst_evo", evo_per, 0);
    tick(); tick();
    rstn = 1'b1;
    exp_q.delete();
    mon_off = 1'b0;
    repeat (10) tick();
    chk("post_rst_no_valid", sto_tvalid, 0);
    chk("post_rst_idle", sts_run, 0);

    // Table write during run: the read in the write cycle sees the old value
    write_tab(5, 500);
    cfg_cyc = 16'(3);
    for (int p = 0; p < 3; p++)
      for (int k = 0; k < 8; k++)
        push((p > 0 && k == 5) ? -8192 : 100 * k, (p == 2) && (k == 7));
    start();
    repeat (5) tick();
    bus_wen = 1'b1; bus_addr = 14'(5); bus_wdata = 14'h2000;
    tick();
    bus_wen = 1'b0;
    drain(80);
    repeat (5) tick();
    chk("wr_sts_cyc", sts_cyc, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=%0d required=%0d", $time, 500000);
    $fatal(1, "timeout");
  end

endmodule
